// File: rtl/spi_rx_ft2_tx_pkg.sv
// Shared definitions for the SPI receive / FT2 write path.
// Holds the write-FSM state encoding, default timing constants and a
// constant-evaluable clog2 used to size counters and FIFO pointers.
package spi_rx_ft2_tx_pkg;

  typedef enum logic [2:0] {
    WS_IDLE    = 3'd0,
    WS_SETUP   = 3'd1,
    WS_STROBE  = 3'd2,
    WS_HOLD    = 3'd3,
    WS_RECOVER = 3'd4
  } wr_state_t;

  localparam int DEF_FIFO_DEPTH = 16;
  localparam int DEF_WR_SETUP   = 2;
  localparam int DEF_WR_PULSE   = 3;
  // Sized to cover the FT2232H txe_n update delay at 60 MHz.
  localparam int DEF_WR_RECOVER = 4;

  // Smallest r with 2**r >= value.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_rx_ft2_tx_sync_fifo.sv
// sync_fifo: single-clock FIFO, generic width and power-of-two depth.
// Latency: a pushed word is visible on pop_dat/count the cycle after push.
// Backpressure: push while full is ignored; pop while empty is ignored.
// Ports: clk, rst (async, active-high); push/push_dat write side;
//        pop/pop_dat read side (pop_dat is the current head, show-ahead);
//        full, empty, count status.
module sync_fifo
  import spi_rx_ft2_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_dat,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  count
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign pop_dat = mem[rd_ptr];

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spi_rx_ft2_tx.sv
// spi_rx_ft2_tx: passive mode-0 SPI byte receiver feeding FT245-style FT2 writes.
// Latency: sclk pin rise acts 3 clk later; byte counted 1 cycle after 8th edge;
//          one FT2 write per 1+WR_SETUP+WR_PULSE+1+WR_RECOVER cycles.
// Backpressure: writes wait for sync ft2_txe_n=0 and bus_gnt; full buffer drops bytes (overflow).
// Ports: clk, rst; en capture enable; spi_sclk/spi_sdo/spi_cs monitored bus;
//        ft2_txe_n, bus_gnt inputs; bus_req, ft2_wr_n, ft2_data_out, ft2_data_oe
//        FT2 side; fifo_count, overflow, frame_err status.
module spi_rx_ft2_tx
  import spi_rx_ft2_tx_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int WR_SETUP   = DEF_WR_SETUP,
  parameter int WR_PULSE   = DEF_WR_PULSE,
  parameter int WR_RECOVER = DEF_WR_RECOVER
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        spi_sclk,
  input  logic                        spi_sdo,
  input  logic                        spi_cs,
  input  logic                        ft2_txe_n,
  input  logic                        bus_gnt,
  output logic                        bus_req,
  output logic                        ft2_wr_n,
  output logic [7:0]                  ft2_data_out,
  output logic                        ft2_data_oe,
  output logic [clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                        overflow,
  output logic                        frame_err
);

  localparam int TW = 16;

  // ---------------- synchronizers ----------------
  logic sclk_s1, sclk_s2, sclk_s3;
  logic sdo_s1, sdo_s2;
  logic cs_s1, cs_s2;
  logic txe_s1, txe_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
      sdo_s1  <= 1'b0;
      sdo_s2  <= 1'b0;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      txe_s1  <= 1'b1;
      txe_s2  <= 1'b1;
    end else begin
      sclk_s1 <= spi_sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      sdo_s1  <= spi_sdo;
      sdo_s2  <= sdo_s1;
      cs_s1   <= spi_cs;
      cs_s2   <= cs_s1;
      txe_s1  <= ft2_txe_n;
      txe_s2  <= txe_s1;
    end
  end

  // ---------------- byte assembly ----------------
  logic       sclk_rise;
  logic [6:0] shift_q;
  logic [2:0] bit_cnt;
  logic       byte_push;
  logic [7:0] byte_dat;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_dat;
  logic       fifo_pop;

  assign sclk_rise = sclk_s2 & ~sclk_s3;
  assign byte_push = en & ~cs_s2 & sclk_rise & (bit_cnt == 3'd7);
  assign byte_dat  = {shift_q, sdo_s2};

  // The counter only advances while cs is low, so the first cycle with cs
  // high and a non-zero count is exactly the cs rise that cut a byte short.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q   <= '0;
      bit_cnt   <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (!en) begin
        bit_cnt <= '0;
      end else if (cs_s2) begin
        if (bit_cnt != 3'd0) frame_err <= 1'b1;
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        shift_q <= byte_dat[6:0];
        bit_cnt <= bit_cnt + 3'd1;   // wraps to 0 on the 8th bit
      end
      if (byte_push && fifo_full) overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (byte_push),
    .push_dat (byte_dat),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus_req <= 1'b0;
    else     bus_req <= (fifo_count != '0);
  end

  // ---------------- FT2 write FSM ----------------
  wr_state_t       state, state_nxt;
  logic [TW-1:0]   tmr;
  logic [TW-1:0]   phase_len;
  logic            phase_done;
  logic            wr_go;

  assign wr_go = ~fifo_empty & ~txe_s2 & bus_gnt;

  always_comb begin
    phase_len = TW'(1);
    case (state)
      WS_SETUP:   phase_len = TW'(WR_SETUP);
      WS_STROBE:  phase_len = TW'(WR_PULSE);
      WS_RECOVER: phase_len = TW'(WR_RECOVER);
      default:    phase_len = TW'(1);
    endcase
  end

  assign phase_done = (tmr == phase_len - TW'(1));

  // State register, phase timer and output data latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= WS_IDLE;
      tmr          <= '0;
      ft2_data_out <= 8'h00;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || state == WS_IDLE) tmr <= '0;
      else                                        tmr <= tmr + TW'(1);
      if (state == WS_IDLE && wr_go) ft2_data_out <= fifo_dat;
    end
  end

  // Next state: once SETUP is entered the write runs to completion.
  always_comb begin
    state_nxt = state;
    case (state)
      WS_IDLE:    if (wr_go)      state_nxt = WS_SETUP;
      WS_SETUP:   if (phase_done) state_nxt = WS_STROBE;
      WS_STROBE:  if (phase_done) state_nxt = WS_HOLD;
      WS_HOLD:    if (phase_done) state_nxt = WS_RECOVER;
      WS_RECOVER: if (phase_done) state_nxt = WS_IDLE;
      default:                    state_nxt = WS_IDLE;
    endcase
  end

  // Outputs decode directly from state so reset forces them idle at once.
  always_comb begin
    ft2_wr_n    = 1'b1;
    ft2_data_oe = 1'b0;
    fifo_pop    = 1'b0;
    case (state)
      WS_IDLE:   fifo_pop = wr_go;
      WS_SETUP:  ft2_data_oe = 1'b1;
      WS_STROBE: begin
        ft2_wr_n    = 1'b0;
        ft2_data_oe = 1'b1;
      end
      WS_HOLD:   ft2_data_oe = 1'b1;
      default:   ;
    endcase
  end

endmodule
